// File: rtl/nn_rd_sched.sv
// Read-transfer scheduler: round-robin arbitration of two loaders onto one nn_rd_buffer,
// drives rd_dma for exactly len DMA beats and tracks the buffer's packing phase.
module nn_rd_sched #(
    parameter int DMA_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [1:0]                i_req,
    input  logic [DMA_ADDR_WIDTH-1:0] i_base_addr0,
    input  logic [DMA_ADDR_WIDTH-1:0] i_base_addr1,
    input  logic [LEN_WIDTH-1:0]      i_len0,
    input  logic [LEN_WIDTH-1:0]      i_len1,
    input  logic [1:0]                i_mode0,
    input  logic [1:0]                i_mode1,
    input  logic                      i_dma_ready,
    output logic [DMA_ADDR_WIDTH-1:0] o_buf_base_addr,
    output logic                      o_buf_rd_dma,
    output logic [1:0]                o_buf_mode,
    output logic [1:0]                o_grant,
    output logic                      o_busy,
    output logic [1:0]                o_done,
    output logic                      o_phase_err,
    output logic                      o_overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_BURST, S_DRAIN, S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [1:0]                  w_pick;
    logic                        w_last;
    logic [1:0]                  w_new_mode;

    logic [DMA_ADDR_WIDTH-1:0]   r_buf_base_addr;
    logic                        r_buf_rd_dma;
    logic [1:0]                  r_buf_mode;
    logic [1:0]                  r_grant;
    logic                        r_busy;
    logic [1:0]                  r_done;
    logic                        r_phase_err;
    logic                        r_overrun;
    logic                        r_rr_last;
    logic                        r_mode_chg;
    logic [LEN_WIDTH-1:0]        r_len;
    logic [LEN_WIDTH-1:0]        r_beat_cnt;
    logic [2:0]                  r_phase_cnt;

    // Words per packing period of the buffer for each kernel mode.
    function automatic logic [2:0] f_period(input logic [1:0] mode);
        case (mode)
            2'b01:   f_period = 3'd1;
            2'b10:   f_period = 3'd5;
            default: f_period = 3'd3;
        endcase
    endfunction

    function automatic logic [2:0] f_phase_next(input logic [2:0] phase, input logic [1:0] mode);
        logic [2:0] inc;
        inc = phase + 3'd1;
        f_phase_next = (inc >= f_period(mode)) ? 3'd0 : inc;
    endfunction

    assign w_last     = (r_beat_cnt + LEN_WIDTH'(1)) == r_len;
    assign w_new_mode = w_pick[1] ? i_mode1 : i_mode0;

    always_comb begin
        w_next = r_state;
        w_pick = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (i_req != 2'b00) begin
                    if (i_req == 2'b11)
                        w_pick = r_rr_last ? 2'b01 : 2'b10;
                    else
                        w_pick = i_req;
                    w_next = S_SETUP;
                end
            end
            S_SETUP: w_next = (r_len == '0) ? S_DONE : S_BURST;
            S_BURST: if (i_dma_ready && w_last) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state         <= S_IDLE;
            r_buf_base_addr <= '0;
            r_buf_rd_dma    <= 1'b0;
            r_buf_mode      <= 2'b00;
            r_grant         <= 2'b00;
            r_busy          <= 1'b0;
            r_done          <= 2'b00;
            r_phase_err     <= 1'b0;
            r_overrun       <= 1'b0;
            r_rr_last       <= 1'b1;
            r_mode_chg      <= 1'b0;
            r_len           <= '0;
            r_beat_cnt      <= '0;
            r_phase_cnt     <= 3'd0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= 2'b00;
            // Beats outside BURST are flagged and never counted.
            if (i_dma_ready && r_state != S_BURST)
                r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_pick != 2'b00) begin
                        r_grant         <= w_pick;
                        r_buf_base_addr <= w_pick[1] ? i_base_addr1 : i_base_addr0;
                        r_len           <= w_pick[1] ? i_len1 : i_len0;
                        r_buf_mode      <= w_new_mode;
                        r_mode_chg      <= (w_new_mode != r_buf_mode);
                    end
                end
                S_SETUP: begin
                    if (r_mode_chg)
                        r_phase_cnt <= 3'd0;
                    if (r_len != '0)
                        r_buf_rd_dma <= 1'b1;
                    else
                        r_done <= r_grant;
                end
                S_BURST: begin
                    if (i_dma_ready) begin
                        r_beat_cnt  <= r_beat_cnt + LEN_WIDTH'(1);
                        r_phase_cnt <= f_phase_next(r_phase_cnt, r_buf_mode);
                        if (w_last)
                            r_buf_rd_dma <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (r_phase_cnt != 3'd0)
                        r_phase_err <= 1'b1;
                    r_done <= r_grant;
                end
                S_DONE: begin
                    r_rr_last  <= r_grant[1];
                    r_grant    <= 2'b00;
                    r_beat_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_buf_base_addr = r_buf_base_addr;
    assign o_buf_rd_dma    = r_buf_rd_dma;
    assign o_buf_mode      = r_buf_mode;
    assign o_grant         = r_grant;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_phase_err     = r_phase_err;
    assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_nn_rd_sched.sv
// Scoreboard bench for nn_rd_sched: directed bursts push expected completions,
// a negedge monitor pops and checks them whenever o_done pulses.
module tb_nn_rd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [31:0] base0, base1;
    logic [15:0] len0, len1;
    logic [1:0]  mode0, mode1;
    logic        dma_ready;
    logic [31:0] buf_base;
    logic        rd_dma;
    logic [1:0]  buf_mode, grant, done;
    logic        busy, phase_err, overrun;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  done;
        logic [31:0] base;
        logic [1:0]  mode;
        int          rd;
        logic        perr;
    } exp_t;
    exp_t exp_q[$];

    nn_rd_sched dut (
        .i_clk(clk), .i_rst(rst_n), .i_req(req),
        .i_base_addr0(base0), .i_base_addr1(base1),
        .i_len0(len0), .i_len1(len1), .i_mode0(mode0), .i_mode1(mode1),
        .i_dma_ready(dma_ready),
        .o_buf_base_addr(buf_base), .o_buf_rd_dma(rd_dma), .o_buf_mode(buf_mode),
        .o_grant(grant), .o_busy(busy), .o_done(done),
        .o_phase_err(phase_err), .o_overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: captures owner/base/mode at grant, counts rd_dma cycles, checks on o_done.
    logic [1:0]  m_prev_grant = 2'b00;
    logic [1:0]  m_prev_done  = 2'b00;
    logic [1:0]  m_cap_grant  = 2'b00;
    logic [31:0] m_cap_base   = '0;
    logic [1:0]  m_cap_mode   = 2'b00;
    int          m_rd_cnt     = 0;
    int          m_since_done = 0;
    bit          m_had_done   = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_grant = 2'b00;
            m_prev_done  = 2'b00;
            m_rd_cnt     = 0;
            m_had_done   = 1'b0;
        end else begin
            m_since_done++;
            if (grant != 2'b00 && m_prev_grant == 2'b00) begin
                m_cap_grant = grant;
                m_cap_base  = buf_base;
                m_cap_mode  = buf_mode;
                m_rd_cnt    = 0;
                if (m_had_done)
                    chk("grant_gap_ge2", 64'(m_since_done >= 2), 64'd1);
            end
            if (rd_dma) m_rd_cnt++;
            if (done != 2'b00) begin
                if (m_prev_done != 2'b00)
                    chk("done_one_cycle", 64'(m_prev_done), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_bits", 64'(done), 64'(e.done));
                    chk("grant_owner", 64'(m_cap_grant), 64'(e.done));
                    chk("base_addr", 64'(m_cap_base), 64'(e.base));
                    chk("buf_mode", 64'(m_cap_mode), 64'(e.mode));
                    chk("rd_dma_cycles", 64'(m_rd_cnt), 64'(e.rd));
                    chk("phase_err", 64'(phase_err), 64'(e.perr));
                    chk("overrun_clean", 64'(overrun), 64'd0);
                end
                m_since_done = 0;
                m_had_done   = 1'b1;
            end
            m_prev_grant = grant;
            m_prev_done  = done;
        end
    end

    task automatic push_exp(input logic [1:0] d, input logic [31:0] b, input logic [1:0] m,
                            input int rd, input logic perr);
        exp_t e;
        e.done = d; e.base = b; e.mode = m; e.rd = rd; e.perr = perr;
        exp_q.push_back(e);
    endtask

    // Serves DMA beats (every cycle or every other rd_dma cycle) and drops requests on done.
    task automatic serve(input bit every_other);
        int k;
        bit ok;
        k  = 0;
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done[0]) req[0] = 1'b0;
            if (done[1]) req[1] = 1'b0;
            dma_ready = rd_dma && (!every_other || (k % 2 == 0));
            if (rd_dma) k++; else k = 0;
            if (req == 2'b00) begin ok = 1'b1; break; end
        end
        dma_ready = 1'b0;
        if (!ok) chk("serve_timeout", 64'd0, 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_base"},   64'(buf_base), 64'd0);
        chk({tag, "_rd_dma"}, 64'(rd_dma), 64'd0);
        chk({tag, "_mode"},   64'(buf_mode), 64'd0);
        chk({tag, "_grant"},  64'(grant), 64'd0);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_done"},   64'(done), 64'd0);
        chk({tag, "_perr"},   64'(phase_err), 64'd0);
        chk({tag, "_ovr"},    64'(overrun), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; req = 2'b00; dma_ready = 1'b0;
        base0 = '0; base1 = '0; len0 = '0; len1 = '0; mode0 = 2'b00; mode1 = 2'b00;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous pairs: ch0 first after reset, then ch1, and the same again.
        for (int p = 0; p < 2; p++) begin
            base0 = 32'h200; len0 = 16'd3; mode0 = 2'b00;
            base1 = 32'h280; len1 = 16'd3; mode1 = 2'b00;
            push_exp(2'b01, 32'h200, 2'b00, 3, 1'b0);
            push_exp(2'b10, 32'h280, 2'b00, 3, 1'b0);
            req = 2'b11;
            serve(1'b0);
        end

        // Single ch0, mode 01, beat every cycle.
        base0 = 32'h100; len0 = 16'd4; mode0 = 2'b01;
        push_exp(2'b01, 32'h100, 2'b01, 4, 1'b0);
        req = 2'b01;
        serve(1'b0);

        // ch1, len 10, mode 10, beat every other cycle: 19 rd_dma cycles.
        base1 = 32'h4000; len1 = 16'd10; mode1 = 2'b10;
        push_exp(2'b10, 32'h4000, 2'b10, 19, 1'b0);
        req = 2'b10;
        serve(1'b1);

        // ch0, len 4, mode 00: 4 mod 3 leaves phase 1.
        base0 = 32'h500; len0 = 16'd4; mode0 = 2'b00;
        push_exp(2'b01, 32'h500, 2'b00, 4, 1'b1);
        req = 2'b01;
        serve(1'b0);

        // ch1, len 0: no rd_dma at all.
        base1 = 32'h600; len1 = 16'd0; mode1 = 2'b01;
        push_exp(2'b10, 32'h600, 2'b01, 0, 1'b1);
        req = 2'b10;
        serve(1'b0);

        // Reset in the middle of a burst, then a stray beat in IDLE.
        base0 = 32'h300; len0 = 16'd8; mode0 = 2'b01;
        req = 2'b01;
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 50 && seen < 3; c++) begin
                @(negedge clk);
                dma_ready = rd_dma;
                if (rd_dma) seen++;
            end
            chk("mid_burst_reached", 64'(seen), 64'd3);
        end
        @(negedge clk);
        rst_n = 1'b0; dma_ready = 1'b0; req = 2'b00;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ovr_before_beat", 64'(overrun), 64'd0);
        dma_ready = 1'b1;
        @(negedge clk);
        dma_ready = 1'b0;
        chk("ovr_after_beat", 64'(overrun), 64'd1);
        chk("idle_after_beat", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("no_done_after_reset", 64'(done), 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
